// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end: frame states,
// scan-code set 2 prefixes, and the set 2 -> HID key map.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_ENTER = 8'h28;
  localparam logic [7:0] HID_ESC   = 8'h29;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_RIGHT = 8'h4F;
  localparam logic [7:0] HID_UP    = 8'h52;
  localparam logic [7:0] HID_DOWN  = 8'h51;

  // Returns HID_NONE for any code outside the map.
  function automatic logic [7:0] ps2_to_hid(input logic ext, input logic [7:0] code);
    logic [7:0] hid;
    hid = HID_NONE;
    if (ext) begin
      case (code)
        SC_LEFT:  hid = HID_LEFT;
        SC_RIGHT: hid = HID_RIGHT;
        SC_UP:    hid = HID_UP;
        SC_DOWN:  hid = HID_DOWN;
        default:  hid = HID_NONE;
      endcase
    end else begin
      case (code)
        SC_A:     hid = HID_A;
        SC_D:     hid = HID_D;
        SC_W:     hid = HID_W;
        SC_S:     hid = HID_S;
        SC_SPACE: hid = HID_SPACE;
        SC_ENTER: hid = HID_ENTER;
        SC_ESC:   hid = HID_ESC;
        default:  hid = HID_NONE;
      endcase
    end
    return hid;
  endfunction

endpackage

// File: rtl/ps2_keycode_if.sv
// Pin-side and keycode-side signals of the PS/2 keycode block.
// master: the keycode block itself; slave: pin driver / keycode consumer.
`timescale 1ns/1ps
interface ps2_keycode_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] keycode;
  logic       key_event;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  modport master (
    input  PS2_CLK, PS2_DAT,
    output keycode, key_event, byte_valid, rx_byte, frame_err
  );

  modport slave (
    output PS2_CLK, PS2_DAT,
    input  keycode, key_event, byte_valid, rx_byte, frame_err
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge strobe, 11-bit frame
// FSM with odd-parity / stop-bit checks and a mid-frame inactivity timeout.
`timescale 1ns/1ps
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [1:0]   clk_sync, dat_sync;
  logic         clk_d, fall, dat_s;

  frame_state_t st_q, st_d;
  logic [2:0]   bit_q, bit_d;
  logic [7:0]   sh_q, sh_d;
  logic         par_q, par_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         bv_d, err_d, err_q, timeout_hit;

  // Sync flops reset high (bus idle) so reset release never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_d    <= 1'b1;
      fall     <= 1'b0;
      dat_s    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_d    <= clk_sync[1];
      fall     <= clk_d & ~clk_sync[1];
      dat_s    <= dat_sync[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= ST_IDLE;
      bit_q      <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      cnt_q      <= '0;
      byte_valid <= 1'b0;
      err_q      <= 1'b0;
      rx_byte    <= '0;
    end else begin
      st_q       <= st_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      cnt_q      <= cnt_d;
      byte_valid <= bv_d;
      err_q      <= err_d;
      if (bv_d) rx_byte <= sh_q;
    end
  end

  always_comb begin
    st_d        = st_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    par_d       = par_q;
    cnt_d       = '0;
    bv_d        = 1'b0;
    err_d       = 1'b0;
    timeout_hit = 1'b0;

    // A fall in the same cycle as the terminal count takes priority.
    if (st_q != ST_IDLE && !fall) begin
      if (cnt_q == TO_LAST) begin
        timeout_hit = 1'b1;
        st_d        = ST_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (st_q)
      ST_IDLE: begin
        if (fall && !dat_s) begin
          st_d  = ST_DATA;
          bit_d = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          sh_d  = {dat_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d = dat_s;
          st_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          st_d = ST_IDLE;
          if (dat_s && (^{sh_q, par_q})) bv_d  = 1'b1;
          else                           err_d = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  assign frame_err = err_q | timeout_hit;

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 keyboard to HID keycode: frame receiver plus the E0/F0 prefix tracker
// that holds the last pressed mapped key until that same key is released.
`timescale 1ns/1ps
module ps2_keycode
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic          Clk,
  input  logic          Reset,
  ps2_keycode_if.master bus
);

  logic [7:0] rx_byte;
  logic       byte_valid, frame_err;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic [7:0] key_q, key_d, hid;
  logic       event_q;

  ps2_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk        (Clk),
    .rst        (Reset),
    .ps2_clk    (bus.PS2_CLK),
    .ps2_dat    (bus.PS2_DAT),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    key_d = key_q;
    hid   = ps2_to_hid(ext_q, rx_byte);
    if (frame_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == PFX_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PFX_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        // Releasing a key other than the held one leaves the held one alone.
        if (hid != HID_NONE) begin
          if (!brk_q)            key_d = hid;
          else if (hid == key_q) key_d = HID_NONE;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      key_q   <= HID_NONE;
      event_q <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      key_q   <= key_d;
      event_q <= (key_d != key_q);
    end
  end

  assign bus.keycode    = key_q;
  assign bus.key_event  = event_q;
  assign bus.byte_valid = byte_valid;
  assign bus.rx_byte    = rx_byte;
  assign bus.frame_err  = frame_err;

endmodule

// File: tb/tb_ps2_keycode.sv
// Bench for ps2_keycode: a table of PS/2 frames with expected keycode and
// pulse counts, then hand-written timeout and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_ps2_keycode;

  localparam int TO   = 200;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_keycode_if bus ();

  ps2_keycode #(.TIMEOUT_CYC(TO)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int ev_cnt = 0, bv_cnt = 0, err_cnt = 0, first_err = 0, last_fall = 0;
  int checks = 0, failures = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.key_event)  ev_cnt = ev_cnt + 1;
      if (bus.byte_valid) bv_cnt = bv_cnt + 1;
      if (bus.frame_err) begin
        if (err_cnt == 0) first_err = cyc;
        err_cnt = err_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    logic [7:0] exp_key;
    int         exp_ev;
    int         exp_bv;
    int         exp_err;
    logic [7:0] exp_rx;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Sends the first nbits of an 11-bit frame (start, 8 data LSB first, parity, stop).
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.PS2_DAT = f[i];
      wait_clk(HALF);
      bus.PS2_CLK = 1'b0;
      last_fall   = cyc;
      wait_clk(HALF);
      bus.PS2_CLK = 1'b1;
    end
    bus.PS2_DAT = 1'b1;
  endtask

  task automatic clear_counts();
    ev_cnt = 0; bv_cnt = 0; err_cnt = 0; first_err = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h1C, 0, 0, 8'h04, 1, 1, 0, 8'h1C};
    vecs[1]  = '{8'hF0, 0, 0, 8'h04, 0, 1, 0, 8'hF0};
    vecs[2]  = '{8'h1C, 0, 0, 8'h00, 1, 1, 0, 8'h1C};
    vecs[3]  = '{8'hE0, 0, 0, 8'h00, 0, 1, 0, 8'hE0};
    vecs[4]  = '{8'h74, 0, 0, 8'h4F, 1, 1, 0, 8'h74};
    vecs[5]  = '{8'hE0, 0, 0, 8'h4F, 0, 1, 0, 8'hE0};
    vecs[6]  = '{8'hF0, 0, 0, 8'h4F, 0, 1, 0, 8'hF0};
    vecs[7]  = '{8'h74, 0, 0, 8'h00, 1, 1, 0, 8'h74};
    vecs[8]  = '{8'h1C, 0, 0, 8'h04, 1, 1, 0, 8'h1C};
    vecs[9]  = '{8'h23, 0, 0, 8'h07, 1, 1, 0, 8'h23};
    vecs[10] = '{8'hF0, 0, 0, 8'h07, 0, 1, 0, 8'hF0};
    vecs[11] = '{8'h1C, 0, 0, 8'h07, 0, 1, 0, 8'h1C};
    vecs[12] = '{8'hF0, 0, 0, 8'h07, 0, 1, 0, 8'hF0};
    vecs[13] = '{8'h23, 0, 0, 8'h00, 1, 1, 0, 8'h23};
    vecs[14] = '{8'h1C, 1, 0, 8'h00, 0, 0, 1, 8'h23};
    vecs[15] = '{8'hF0, 0, 0, 8'h00, 0, 1, 0, 8'hF0};
    vecs[16] = '{8'h23, 0, 1, 8'h00, 0, 0, 1, 8'hF0};
    vecs[17] = '{8'h23, 0, 0, 8'h07, 1, 1, 0, 8'h23};
    vecs[18] = '{8'h12, 0, 0, 8'h07, 0, 1, 0, 8'h12};
    vecs[19] = '{8'h23, 0, 0, 8'h07, 0, 1, 0, 8'h23};
    vecs[20] = '{8'hE0, 0, 0, 8'h07, 0, 1, 0, 8'hE0};
    vecs[21] = '{8'h75, 0, 0, 8'h52, 1, 1, 0, 8'h75};

    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    wait_clk(5);
    check("rst_keycode", bus.keycode, 8'h00);
    check("rst_rx_byte", bus.rx_byte, 8'h00);
    check("rst_key_event", bus.key_event, 0);
    check("rst_byte_valid", bus.byte_valid, 0);
    check("rst_frame_err", bus.frame_err, 0);
    rst = 1'b0;
    wait_clk(5);

    for (int i = 0; i < NV; i++) begin
      clear_counts();
      send_bits(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop, 11);
      wait_clk(40);
      check($sformatf("v%0d_keycode", i), bus.keycode, vecs[i].exp_key);
      check($sformatf("v%0d_key_events", i), ev_cnt, vecs[i].exp_ev);
      check($sformatf("v%0d_byte_valids", i), bv_cnt, vecs[i].exp_bv);
      check($sformatf("v%0d_frame_errs", i), err_cnt, vecs[i].exp_err);
      check($sformatf("v%0d_rx_byte", i), bus.rx_byte, vecs[i].exp_rx);
    end

    // Extended flag must have cleared: plain 1D is W, not an arrow.
    clear_counts();
    send_bits(8'h1D, 0, 0, 11);
    wait_clk(40);
    check("ext_clear_keycode", bus.keycode, 8'h1A);

    // Clock stalls after 4 data bits; error lands TO cycles after the fall strobe,
    // which trails the pin edge by 3 clock edges.
    clear_counts();
    send_bits(8'h5A, 0, 0, 5);
    for (int k = 0; k < TO + 80 && err_cnt == 0; k++) wait_clk(1);
    wait_clk(20);
    check("timeout_err_count", err_cnt, 1);
    check("timeout_latency", first_err - last_fall, TO + 3);
    check("timeout_no_valid", bv_cnt, 0);
    check("timeout_keycode", bus.keycode, 8'h1A);
    clear_counts();
    send_bits(8'h1C, 0, 0, 11);
    wait_clk(40);
    check("post_timeout_keycode", bus.keycode, 8'h04);
    check("post_timeout_errs", err_cnt, 0);

    // Reset in the middle of a frame while D is held.
    send_bits(8'h23, 0, 0, 11);
    wait_clk(40);
    check("pre_reset_keycode", bus.keycode, 8'h07);
    send_bits(8'h1C, 0, 0, 3);
    rst = 1'b1;
    #1;
    check("midrst_keycode", bus.keycode, 8'h00);
    check("midrst_rx_byte", bus.rx_byte, 8'h00);
    check("midrst_key_event", bus.key_event, 0);
    check("midrst_byte_valid", bus.byte_valid, 0);
    check("midrst_frame_err", bus.frame_err, 0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(5);
    clear_counts();
    send_bits(8'h23, 0, 0, 11);
    wait_clk(40);
    check("post_reset_keycode", bus.keycode, 8'h07);
    check("post_reset_events", ev_cnt, 1);
    check("post_reset_rx_byte", bus.rx_byte, 8'h23);
    check("post_reset_errs", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_keycode.md
# ps2_keycode

- Receives PS/2 scan-code set 2 frames from the keyboard and produces the 8-bit HID-style `keycode` consumed by the ball movement logic: 0x04 is left/A, 0x07 is right/D.
- Sits between the board's PS/2 pins and every `keycode` consumer (ball, game control).
- Tracks make/break and E0-extended prefixes so that `keycode` holds a pressed key's code until that key is released.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 100000: `Clk` cycles with no PS/2 falling edge mid-frame before the frame is abandoned (2 ms at 50 MHz).

Ports:
- `Clk`, input, 1: system clock, 50 MHz; the single clock domain.
- `Reset`, input, 1: asynchronous, active-high reset.
- `PS2_CLK`, input, 1: keyboard clock, asynchronous, idles high.
- `PS2_DAT`, input, 1: keyboard data, asynchronous, sampled on `PS2_CLK` falling edges.
- `keycode`, output, 8: HID code of the currently held mapped key; 0x00 when none is held.
- `key_event`, output, 1: one-cycle pulse whenever `keycode` changes value.
- `byte_valid`, output, 1: one-cycle pulse for each correctly framed received byte.
- `rx_byte`, output, 8: last correctly framed byte; held until the next one.
- `frame_err`, output, 1: one-cycle pulse on a parity error, bad stop bit, or timeout.

## Operation
Input conditioning:
- `PS2_CLK` and `PS2_DAT` each pass through a 2-flop synchronizer.
- A falling edge on the synchronized clock produces a one-cycle `fall` strobe.

Frame FSM (`IDLE` → `DATA` → `PARITY` → `STOP` → `IDLE`):
- `IDLE`: on `fall` with data=0 (start bit), go to `DATA` with the bit counter at 0. On `fall` with data=1, stay in `IDLE` and flag no error.
- `DATA`: shift in 8 bits, LSB first. A 3-bit counter advances on each `fall`; after bit 7, go to `PARITY`.
- `PARITY`: capture the parity bit. The frame is good when data plus parity contains an odd number of ones.
- `STOP`: on `fall`, if stop=1 and parity is good, pulse `byte_valid` and load `rx_byte`. Otherwise pulse `frame_err` and discard the byte. Return to `IDLE` in both cases.
- Timeout: a counter runs in every state except `IDLE` and clears on each `fall`. When it reaches `TIMEOUT_CYC`-1, the FSM returns to `IDLE` and pulses `frame_err`.

Decode layer (acts on `byte_valid` only):
- 0xE0 sets the `ext` flag. 0xF0 sets the `brk` flag. Both flags persist until the next non-prefix byte.
- Any other byte is looked up with `ext` through the map below, then both flags clear.
- Make (`brk`=0) of a mapped key: `keycode` ← mapped code; this is last-press-wins.
- Break (`brk`=1) of a mapped key: `keycode` ← 0x00 only if the mapped code equals the current `keycode`. Otherwise `keycode` is unchanged.
- Unmapped byte: no change to `keycode`; flags still clear.
- `frame_err` clears `ext` and `brk`.
- `key_event` pulses in the cycle `keycode` takes a value different from its previous one. A typematic repeat of the held key produces no pulse.

Map (set 2 → HID):
- Non-extended: 1C→04 (A), 23→07 (D), 1D→1A (W), 1B→16 (S), 29→2C (space), 5A→28 (enter), 76→29 (esc).
- Extended (E0): 6B→50 (left), 74→4F (right), 75→52 (up), 72→51 (down).

## Timing
Reset values (all outputs): `keycode`=0x00, `rx_byte`=0x00, all pulses 0, FSM in `IDLE`, flags clear, counters 0.

Latency:
- A pin falling edge appears as `fall` 3 `Clk` edges later: 2 synchronizer stages plus the edge register.
- `byte_valid` is asserted in the cycle after the `fall` of the stop bit.
- `keycode` and `key_event` update 1 cycle after `byte_valid`, giving a registered decode.

Simultaneous events:
- Timeout and `fall` in the same cycle: `fall` wins.
- `Reset` asserted mid-frame: immediate return to the reset state; the partial frame is lost.

## Structure
- `ps2_pkg`: frame-state enum, prefix constants (8'hE0, 8'hF0), scan-code and HID localparams, and the map function `ps2_to_hid(ext, code)`, which returns 0x00 when the code is unmapped.
- Sub-module `ps2_frame_rx`: synchronizer, edge detect, frame FSM and timeout. It outputs `rx_byte`, `byte_valid` and `frame_err`.
- `ps2_keycode`: instantiates `ps2_frame_rx` and adds the prefix/decode register layer.

## Test plan
- Frames 1C, then F0 1C, each with correct odd parity at a 12.5 kHz PS/2 clock. Expect `keycode`=04 with one `key_event` pulse, then 00 with a second `key_event` pulse.
- E0 74, then E0 F0 74. Expect `keycode`=4F, then 00. Expect `rx_byte` to read E0, 74, E0, F0, 74 in sequence.
- Make 1C, make 23, break 1C, break 23. Expect `keycode` 04 → 07 → 07 (unchanged) → 00, with exactly 3 `key_event` pulses.
- Frame 1C with the parity bit inverted. Expect one `frame_err` pulse, no `byte_valid`, and `keycode` unchanged. Then send F0 23 with the stop bit at 0: expect `frame_err`, `brk` cleared, and a following valid 23 treated as a make (`keycode`=07).
- Stop `PS2_CLK` after 4 data bits. Expect `frame_err` exactly `TIMEOUT_CYC` cycles after the last `fall`; a following complete frame 1C then decodes correctly to 04.
- Assert `Reset` mid-frame while `keycode`=07. Expect all outputs at reset values immediately, and the next complete 23 frame yields 07.
